pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 16-bit five-stage pipeline (IF, ID, EXE, DM, WB).
- Detects load-use hazards between ID and EXE.
- Squashes wrong-path instructions when a branch resolves taken in EXE.
- Freezes the whole pipeline while a multi-cycle data-memory access completes.
- Keeps a memory-timeout error state and saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive DM wait cycles before the error state is entered.
CNT_W, 16, width of the stall and flush performance counters.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  4  ID source register 1
id_rs2  in  4  ID source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
exe_memRead  in  1  EXE instruction is a load
exe_wen  in  1  EXE instruction writes the register file
exe_waddr  in  4  EXE destination register
branch_taken  in  1  branch in EXE resolved taken this cycle
dm_req  in  1  DM stage performs memRead or memWrite
dm_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID to a bubble
id_exe_stall  out  1  hold ID/EXE register
id_exe_bubble  out  1  load a bubble into ID/EXE (branch, wen, memRead, memWrite forced 0)
exe_dm_stall  out  1  hold EXE/DM register
dm_wb_bubble  out  1  load a bubble into DM/WB (wen_DM_WB forced 0)
mem_timeout  out  1  sticky error flag
ctrl_state  out  2  encoded state: 0 RUN, 1 MEM_WAIT, 2 ERROR
stall_cycles  out  CNT_W  count of cycles with pc_stall=1, saturating
flush_count  out  CNT_W  count of cycles with if_id_flush=1, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, wait counter=0, mem_timeout=0, both performance counters=0.
  - All stall/flush outputs decode to 0 while the inputs are idle.
- Stall and flush outputs are combinational from the current state and the inputs, so they take effect in the same cycle. The state and all counters are registered.
- Definitions:
  - load_use = exe_memRead & exe_wen & (exe_waddr!=0) & id_valid & ((id_uses_rs1 & id_rs1==exe_waddr) | (id_uses_rs2 & id_rs2==exe_waddr)).
  - freeze = (state==RUN & dm_req & !dm_ready) | (state==MEM_WAIT & !dm_ready) | state==ERROR.
- Output priority, highest first:
  - freeze: pc_stall, if_id_stall, id_exe_stall, exe_dm_stall and dm_wb_bubble are 1; the flush and bubble outputs for IF/ID and ID/EXE are 0.
  - else branch_taken: if_id_flush=1, id_exe_bubble=1, all other outputs 0. A simultaneous load_use is ignored because the ID instruction is squashed.
  - else load_use: pc_stall=1, if_id_stall=1, id_exe_bubble=1, all other outputs 0. This gives a one-cycle interlock; the hazard clears when the load advances to DM.
  - else all stall/flush outputs are 0.
- A branch_taken that arrives during a freeze is held in EXE by the freeze. The flush is issued on the first unfrozen cycle.
- State machine:
  - RUN:
    - dm_req & !dm_ready -> MEM_WAIT, wait counter set to 1.
    - dm_req & dm_ready -> stay in RUN, no stall.
  - MEM_WAIT:
    - dm_ready -> RUN, wait counter cleared. That cycle is unfrozen; DM/WB captures the result.
    - !dm_ready & wait counter==MEM_TIMEOUT -> ERROR, mem_timeout set to 1.
    - !dm_ready otherwise -> wait counter incremented.
  - ERROR: permanent freeze; only rst exits. dm_ready is ignored.
- dm_req is sampled only in RUN. In MEM_WAIT the outstanding request is assumed held.
- Counters:
  - stall_cycles increments on every cycle with pc_stall=1.
  - flush_count increments on every cycle with if_id_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted in MEM_WAIT or ERROR returns immediately to RUN with the counters cleared.

Test Plan:
1. Load-use: exe_memRead=1, exe_wen=1, exe_waddr=3, id_rs2=3, id_uses_rs2=1, dm_req=0 for 1 cycle -> pc_stall=if_id_stall=id_exe_bubble=1 that cycle, stall_cycles 0->1. Repeat with exe_waddr=0 -> no stall.
2. Branch vs load-use: branch_taken=1 together with the load-use condition from scenario 1 -> if_id_flush=1, id_exe_bubble=1, pc_stall=0, flush_count 0->1.
3. Memory wait: dm_req=1, dm_ready=0 for 4 cycles, then dm_ready=1 -> freeze outputs=1 for exactly 4 cycles, ctrl_state=1 during the wait, 0 on the ready cycle, stall_cycles=4.
4. Branch during freeze: branch_taken=1 held through a 3-cycle wait -> if_id_flush=0 while frozen, 1 on the dm_ready cycle; flush_count=1.
5. Timeout: dm_req=1, dm_ready never asserted -> ctrl_state=2 and mem_timeout=1 after MEM_TIMEOUT+1 frozen cycles (16 for the default); pulsing dm_ready=1 keeps the freeze; rst=0 mid-cycle clears to RUN immediately with counters=0.
6. Saturation: CNT_W=4, hold freeze for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use interlock, taken-branch squash,
// data-memory wait freeze with timeout, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             exe_memRead,
    input  logic             exe_wen,
    input  logic [3:0]       exe_waddr,
    input  logic             branch_taken,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_exe_stall,
    output logic             id_exe_bubble,
    output logic             exe_dm_stall,
    output logic             dm_wb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StError   = 2'd2
    } state_e;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              load_use;
    logic              freeze;

    assign load_use = exe_memRead && exe_wen && (exe_waddr != 4'd0) && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == exe_waddr)) ||
                       (id_uses_rs2 && (id_rs2 == exe_waddr)));

    assign freeze = ((state_q == StRun) && dm_req && !dm_ready) ||
                    ((state_q == StMemWait) && !dm_ready) ||
                    (state_q == StError);

    // Freeze outranks branch because a frozen EXE holds the branch until it can flush.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_stall  = 1'b0;
        id_exe_bubble = 1'b0;
        exe_dm_stall  = 1'b0;
        dm_wb_bubble  = 1'b0;
        if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_exe_stall = 1'b1;
            exe_dm_stall = 1'b1;
            dm_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (dm_req && !dm_ready) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= WAIT_W'(1);
                    end
                end
                StMemWait: begin
                    if (dm_ready) begin
                        state_q    <= StRun;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_q     <= StError;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    state_q    <= StRun;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    assign ctrl_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pc_stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (if_id_flush && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: decode vector table plus multi-cycle freeze,
// timeout, reset and counter-saturation sequences.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [3:0]  id_rs1, id_rs2, exe_waddr;
    logic        exe_memRead, exe_wen, branch_taken, dm_req, dm_ready;

    logic        pc_stall, if_id_stall, if_id_flush, id_exe_stall;
    logic        id_exe_bubble, exe_dm_stall, dm_wb_bubble, mem_timeout;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles, flush_count;

    logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_exe_stall;
    logic        s_id_exe_bubble, s_exe_dm_stall, s_dm_wb_bubble, s_mem_timeout;
    logic [1:0]  s_ctrl_state;
    logic [3:0]  s_stall_cycles, s_flush_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .exe_memRead(exe_memRead),
        .exe_wen(exe_wen), .exe_waddr(exe_waddr), .branch_taken(branch_taken),
        .dm_req(dm_req), .dm_ready(dm_ready), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_exe_stall(id_exe_stall), .id_exe_bubble(id_exe_bubble),
        .exe_dm_stall(exe_dm_stall), .dm_wb_bubble(dm_wb_bubble), .mem_timeout(mem_timeout),
        .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .exe_memRead(exe_memRead),
        .exe_wen(exe_wen), .exe_waddr(exe_waddr), .branch_taken(branch_taken),
        .dm_req(dm_req), .dm_ready(dm_ready), .pc_stall(s_pc_stall),
        .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
        .id_exe_stall(s_id_exe_stall), .id_exe_bubble(s_id_exe_bubble),
        .exe_dm_stall(s_exe_dm_stall), .dm_wb_bubble(s_dm_wb_bubble),
        .mem_timeout(s_mem_timeout), .ctrl_state(s_ctrl_state),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    // {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_bubble, exe_dm_stall, dm_wb_bubble}
    wire [6:0] outs = {pc_stall, if_id_stall, if_id_flush, id_exe_stall,
                       id_exe_bubble, exe_dm_stall, dm_wb_bubble};
    localparam logic [6:0] O_NONE   = 7'b0000000;
    localparam logic [6:0] O_FREEZE = 7'b1101011;
    localparam logic [6:0] O_BRANCH = 7'b0010100;
    localparam logic [6:0] O_LDUSE  = 7'b1100100;

    typedef struct {
        logic       vld;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       wen;
        logic [3:0] waddr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        exe_memRead = 0; exe_wen = 0; exe_waddr = 0; branch_taken = 0;
        dm_req = 0; dm_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge; reset is pulsed well clear of the next edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, " reset state"}, ctrl_state, 2'd0);
        chk({tag, " reset stall_cycles"}, stall_cycles, 16'd0);
        chk({tag, " reset flush_count"}, flush_count, 16'd0);
        chk({tag, " reset mem_timeout"}, mem_timeout, 1'b0);
        idle_inputs();
        #1;
        rst = 1'b1;
    endtask

    task automatic load_use_inputs();
        id_valid = 1; id_uses_rs2 = 1; id_rs2 = 4'd3;
        exe_memRead = 1; exe_wen = 1; exe_waddr = 4'd3;
    endtask

    initial begin
        int exp_stall;
        int exp_flush;

        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE};    // idle
        vecs[1]  = '{1, 0, 3, 0, 1, 1, 1, 3, 0, 0, 0, O_LDUSE};   // load-use on rs2
        vecs[2]  = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, O_NONE};    // r0 destination
        vecs[3]  = '{1, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0, O_LDUSE};   // load-use on rs1
        vecs[4]  = '{1, 5, 0, 0, 0, 1, 1, 5, 0, 0, 0, O_NONE};    // rs1 match, not read
        vecs[5]  = '{0, 0, 3, 0, 1, 1, 1, 3, 0, 0, 0, O_NONE};    // ID invalid
        vecs[6]  = '{1, 0, 3, 0, 1, 1, 0, 3, 0, 0, 0, O_NONE};    // load without wen
        vecs[7]  = '{1, 0, 3, 0, 1, 0, 1, 3, 0, 0, 0, O_NONE};    // ALU op, forwardable
        vecs[8]  = '{1, 0, 3, 0, 1, 1, 1, 3, 1, 0, 0, O_BRANCH};  // branch beats load-use
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BRANCH};  // branch alone
        vecs[10] = '{1, 0, 3, 0, 1, 1, 1, 3, 0, 1, 1, O_LDUSE};   // one-cycle DM access
        vecs[11] = '{1, 0, 4, 0, 1, 1, 1, 3, 0, 0, 0, O_NONE};    // register mismatch

        idle_inputs();
        rst = 1'b0;
        #1;
        chk("por state", ctrl_state, 2'd0);
        chk("por outputs", outs, O_NONE);
        chk("por stall_cycles", stall_cycles, 16'd0);
        chk("por flush_count", flush_count, 16'd0);
        chk("por mem_timeout", mem_timeout, 1'b0);
        #2;
        rst = 1'b1;
        tick();

        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 12; i++) begin
            id_valid = vecs[i].vld; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            exe_memRead = vecs[i].mr; exe_wen = vecs[i].wen; exe_waddr = vecs[i].waddr;
            branch_taken = vecs[i].br; dm_req = vecs[i].req; dm_ready = vecs[i].rdy;
            #2;
            chk($sformatf("vec%0d outputs", i), outs, vecs[i].exp);
            exp_stall += int'(vecs[i].exp[6]);
            exp_flush += int'(vecs[i].exp[4]);
            tick();
            chk($sformatf("vec%0d state", i), ctrl_state, 2'd0);
            chk($sformatf("vec%0d stall_cycles", i), stall_cycles, exp_stall);
            chk($sformatf("vec%0d flush_count", i), flush_count, exp_flush);
        end

        // Memory wait: four frozen cycles, then the ready cycle is unfrozen.
        pulse_reset("memwait");
        tick();
        dm_req = 1; dm_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("memwait freeze%0d", i), outs, O_FREEZE);
            tick();
            chk($sformatf("memwait state%0d", i), ctrl_state, 2'd1);
        end
        dm_ready = 1;
        #2;
        chk("memwait ready outputs", outs, O_NONE);
        tick();
        chk("memwait back to run", ctrl_state, 2'd0);
        chk("memwait stall_cycles", stall_cycles, 16'd4);
        idle_inputs();

        // Branch held through a three-cycle wait flushes only on the ready cycle.
        pulse_reset("brfreeze");
        tick();
        branch_taken = 1; dm_req = 1; dm_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("brfreeze frozen%0d", i), outs, O_FREEZE);
            tick();
        end
        dm_ready = 1;
        #2;
        chk("brfreeze flush", outs, O_BRANCH);
        tick();
        chk("brfreeze flush_count", flush_count, 16'd1);
        chk("brfreeze stall_cycles", stall_cycles, 16'd3);
        idle_inputs();

        // Timeout: 16 frozen cycles lead to ERROR, which ignores dm_ready.
        pulse_reset("timeout");
        tick();
        dm_req = 1; dm_ready = 0;
        for (int i = 0; i < 16; i++) begin
            #2;
            chk($sformatf("timeout freeze%0d", i), pc_stall, 1'b1);
            tick();
            if (i == 14) begin
                chk("timeout state before limit", ctrl_state, 2'd1);
                chk("timeout flag before limit", mem_timeout, 1'b0);
            end
        end
        chk("timeout state error", ctrl_state, 2'd2);
        chk("timeout flag set", mem_timeout, 1'b1);
        dm_ready = 1;
        #2;
        chk("error ignores ready", outs, O_FREEZE);
        tick();
        chk("error sticky", ctrl_state, 2'd2);
        chk("error stall_cycles", stall_cycles, 16'd17);
        #2;
        rst = 1'b0;
        #1;
        chk("error async reset state", ctrl_state, 2'd0);
        chk("error async reset flag", mem_timeout, 1'b0);
        chk("error async reset stalls", stall_cycles, 16'd0);
        idle_inputs();
        #1;
        rst = 1'b1;
        tick();

        // Saturation: the CNT_W=4 instance stops at 15 while the wide one keeps counting.
        pulse_reset("sat");
        tick();
        dm_req = 1; dm_ready = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) chk("sat 14 cycles", s_stall_cycles, 4'd14);
            if (i == 14) chk("sat 15 cycles", s_stall_cycles, 4'd15);
        end
        chk("sat held at max", s_stall_cycles, 4'd15);
        chk("sat wide counter", stall_cycles, 16'd20);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
